// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-way ALU arbiter.
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'b1000;
    localparam alu_ctrl_t ALU_SUB = 4'b1001;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between two requesters and the ALU arbiter.
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int unsigned N = 8
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    alu_ctrl_t [1:0]     req_op;
    logic [1:0][N-1:0]   req_a;
    logic [1:0][N-1:0]   req_b;

    logic                resp_valid;
    logic                resp_ready;
    logic                resp_id;
    logic [N-1:0]        resp_result;
    logic [3:0]          resp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_flags
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0] & (~req_valid[1] | rr_last);
        grant[1] = req_valid[1] & (~req_valid[0] | ~rr_last);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional sticky per-requester overflow flags: define ALU_ARB_STICKY_OVF_EN.
module alu_arbiter import alu_pkg::*; #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_ctrl_t    alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    output logic [1:0]   sticky_ovf,
    input  logic [1:0]   ovf_clr
`endif
);

    arb_state_t   state_q;
    logic         rr_last_q;
    logic [1:0]   grant;
    logic         win;
    logic         resp_valid_q;
    logic         resp_id_q;
    logic [N-1:0] resp_result_q;
    logic [3:0]   resp_flags_q;

    rr_arbiter2 u_rr (
        .req_valid (bus.req_valid),
        .rr_last   (rr_last_q),
        .grant     (grant)
    );

    assign win              = grant[1];
    assign bus.req_ready    = (state_q == IDLE) ? grant : 2'b00;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_result  = resp_result_q;
    assign bus.resp_flags   = resp_flags_q;

    // ALU drive registers double as the capture registers; they are non-zero only in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctrl      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|(bus.req_valid & bus.req_ready)) begin
                        alu_a     <= bus.req_a[win];
                        alu_b     <= bus.req_b[win];
                        alu_ctrl  <= bus.req_op[win];
                        resp_id_q <= win;
                        rr_last_q <= win;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q <= alu_result;
                    resp_flags_q  <= alu_flags;
                    resp_valid_q  <= 1'b1;
                    alu_a         <= '0;
                    alu_b         <= '0;
                    alu_ctrl      <= '0;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] ovf_set;

    always_comb begin
        ovf_set = 2'b00;
        if (state_q == EXEC && alu_flags[FLAG_V] && alu_ctrl[3:1] == ALU_ADD[3:1]) begin
            ovf_set[resp_id_q] = 1'b1;
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_ovf <= 2'b00;
        end else begin
            sticky_ovf <= (sticky_ovf & ~ovf_clr) | ovf_set;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a flag-correct 8-bit ALU model.
// Sticky-overflow checks are compiled in when ALU_ARB_STICKY_OVF_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_a, alu_b, alu_result;
    alu_ctrl_t  alu_ctrl;
    logic [3:0] alu_flags;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] sticky_ovf;
    logic [1:0] ovf_clr;
`endif

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if #(.N(8)) bus ();

    alu_arbiter #(.N(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
`ifdef ALU_ARB_STICKY_OVF_EN
        ,
        .sticky_ovf (sticky_ovf),
        .ovf_clr    (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: add/sub with carry = no-borrow, other codes act as AND.
    logic [8:0] sum9;
    logic       c_f, v_f;
    always_comb begin
        sum9       = 9'd0;
        c_f        = 1'b0;
        v_f        = 1'b0;
        alu_result = alu_a & alu_b;
        case (alu_ctrl)
            ALU_ADD: begin
                sum9       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum9[7:0];
                c_f        = sum9[8];
                v_f        = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            ALU_SUB: begin
                sum9       = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                alu_result = sum9[7:0];
                c_f        = sum9[8];
                v_f        = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            default: ;
        endcase
        alu_flags = {alu_result[7], alu_result == 8'h00, c_f, v_f};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Single request from requester id with resp_ready held high.
    task automatic do_op(input int id, input alu_ctrl_t op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
        bus.req_valid      = 2'b00;
        bus.req_valid[id]  = 1'b1;
        bus.req_op[id]     = op;
        bus.req_a[id]      = a;
        bus.req_b[id]      = b;
        bus.resp_ready     = 1'b1;
        #1;
        check("op_grant", bus.req_ready, (id == 0) ? 2'b01 : 2'b10);
        tick();
        bus.req_valid = 2'b00;
        check("op_exec_ctrl", alu_ctrl, op);
        check("op_exec_a", alu_a, a);
        check("op_exec_b", alu_b, b);
        check("op_exec_ready", bus.req_ready, 2'b00);
        check("op_exec_rvalid", bus.resp_valid, 1'b0);
        tick();
        check("op_resp_valid", bus.resp_valid, 1'b1);
        check("op_resp_id", bus.resp_id, id[0]);
        check("op_resp_result", bus.resp_result, er);
        check("op_resp_flags", bus.resp_flags, ef);
        check("op_resp_alu_ctrl", alu_ctrl, 4'b0000);
        tick();
        check("op_done_rvalid", bus.resp_valid, 1'b0);
    endtask

    initial begin
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clr = 2'b00;
`endif
        do_reset();
        check("rst_rvalid", bus.resp_valid, 1'b0);
        check("rst_ready", bus.req_ready, 2'b00);
        check("rst_ctrl", alu_ctrl, 4'b0000);
        check("rst_a", alu_a, 8'h00);
        check("rst_result", bus.resp_result, 8'h00);
        check("rst_flags", bus.resp_flags, 4'h0);
        check("rst_id", bus.resp_id, 1'b0);
`ifdef ALU_ARB_STICKY_OVF_EN
        check("rst_sticky", sticky_ovf, 2'b00);
`endif

        do_op(0, ALU_ADD, 8'h05, 8'h03, 8'h08, 4'b0000);

        // Fresh reset: requester 0 wins the first tie, then strict alternation.
        do_reset();
        bus.req_op[0] = ALU_ADD; bus.req_a[0] = 8'h0A; bus.req_b[0] = 8'h14;
        bus.req_op[1] = ALU_SUB; bus.req_a[1] = 8'h32; bus.req_b[1] = 8'h08;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_exec_ready", bus.req_ready, 2'b00);
            tick();
            check("rr_resp_valid", bus.resp_valid, 1'b1);
            check("rr_resp_id", bus.resp_id, k[0]);
            check("rr_resp_result", bus.resp_result, (k % 2 == 0) ? 8'h1E : 8'h2A);
            check("rr_resp_flags", bus.resp_flags, (k % 2 == 0) ? 4'b0000 : 4'b0010);
            tick();
        end
        bus.req_valid = 2'b00;
`ifdef ALU_ARB_STICKY_OVF_EN
        check("rr_sticky", sticky_ovf, 2'b00);
`endif

        do_op(1, ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001);
`ifdef ALU_ARB_STICKY_OVF_EN
        check("ovf_sticky_set", sticky_ovf, 2'b10);
        tick();
        check("ovf_sticky_hold", sticky_ovf, 2'b10);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        check("ovf_sticky_clr", sticky_ovf, 2'b00);
`endif

        // Backpressure: other requesters keep asking while the response stalls.
        bus.resp_ready = 1'b0;
        bus.req_op[0] = ALU_ADD; bus.req_a[0] = 8'h11; bus.req_b[0] = 8'h22;
        bus.req_valid = 2'b01;
        #1;
        check("bp_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.resp_valid, 1'b1);
            check("bp_result", bus.resp_result, 8'h33);
            check("bp_id", bus.resp_id, 1'b0);
            check("bp_ready", bus.req_ready, 2'b00);
            tick();
        end
        bus.resp_ready = 1'b1;
        check("bp_accept_valid", bus.resp_valid, 1'b1);
        tick();
        check("bp_idle_rvalid", bus.resp_valid, 1'b0);
        check("bp_idle_grant", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        #1;
        check("bp_drop_ready", bus.req_ready, 2'b00);

        // Reset during EXEC discards the op.
        bus.req_op[0] = ALU_SUB; bus.req_a[0] = 8'h09; bus.req_b[0] = 8'h04;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        check("mid_exec_ctrl", alu_ctrl, ALU_SUB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rvalid", bus.resp_valid, 1'b0);
        check("mid_ctrl", alu_ctrl, 4'b0000);
        check("mid_ready", bus.req_ready, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_resp", bus.resp_valid, 1'b0);
        end

        do_op(0, ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011);
        do_op(0, ALU_SUB, 8'h05, 8'h03, 8'h02, 4'b0010);
`ifdef ALU_ARB_STICKY_OVF_EN
        check("sub_sticky", sticky_ovf, 2'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
